// File: rtl/ti_share_pkg.sv
// ----------------------------------------------------------------------------
// ti_share_pkg
// Shared constants, FSM state type and helper functions for the TI share
// encoder slice.
//   DW       width of one nibble and of each share
//   NSHARES  number of Boolean shares produced
//   LFSR_W   width of the mask LFSR
//   RND_W    mask bits collected per nibble (two mask shares of DW bits)
//   TAPS     Galois feedback taps of the right-shifting LFSR
//   SEED     reset value of the LFSR, also replaces an all-zero seed
// ----------------------------------------------------------------------------
package ti_share_pkg;

    localparam int DW      = 4;
    localparam int NSHARES = 3;
    localparam int LFSR_W  = 16;
    localparam int RND_W   = 2 * DW;
    localparam int CNT_W   = 3;

    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED = 16'hACE1;

    // Last collection cycle: cnt counts 0..7 while 8 mask bits are gathered.
    localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // One step of the right-shift Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? TAPS : '0);
    endfunction

    // Forms {s2, s1, s0}: the two mask shares come straight from the
    // collected random bits, s0 carries the data so all three XOR to it.
    function automatic logic [NSHARES*DW-1:0] share_pack(input logic [DW-1:0]    data,
                                                         input logic [RND_W-1:0] rnd);
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        s1 = rnd[DW-1:0];
        s2 = rnd[RND_W-1:DW];
        return {s2, s1, data ^ s1 ^ s2};
    endfunction

endpackage

// File: rtl/ti_lfsr16.sv
// ----------------------------------------------------------------------------
// ti_lfsr16
// 16-bit right-shift Galois LFSR used as the mask source.
//   clk      rising-edge clock
//   rst      synchronous active-high reset, loads SEED
//   step     advance the LFSR by one step
//   load     load seed_in (priority over step); zero seeds become SEED
//   seed_in  new seed value
//   value    current LFSR contents
// ----------------------------------------------------------------------------
module ti_lfsr16
    import ti_share_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            // An all-zero state would lock the LFSR, so substitute SEED.
            value <= (seed_in == '0) ? SEED : seed_in;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/ti_share_encoder.sv
// ----------------------------------------------------------------------------
// ti_share_encoder
// Splits a plain nibble into three Boolean shares {s2, s1, s0} for the TI
// S-box stage. Eight mask bits are drawn from an internal LFSR per nibble.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds in_data while in_valid is high; in_ready is
// high only in IDLE. out_valid/out_shares stay stable until out_ready is
// seen high with out_valid; no transfer on the other side is combinationally
// dependent on the opposite side's signals.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   seed_load    load seed_in into the LFSR this cycle
//   seed_in      LFSR seed (zero substituted by SEED)
//   in_valid/in_ready/in_data       input nibble handshake
//   out_valid/out_ready/out_shares  output shares handshake, {s2,s1,s0}
//   dbg_state    current FSM state
//   dbg_lfsr     current LFSR contents
//   err          (only with TI_SHARE_CHECK_EN) sticky recombination error
//
// Optional build macro: TI_SHARE_CHECK_EN adds the err port and a checker
// that recombines the emitted shares and compares them with the data.
// ----------------------------------------------------------------------------
module ti_share_encoder
    import ti_share_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NSHARES*DW-1:0]   out_shares,
    output logic [1:0]              dbg_state,
    output logic [LFSR_W-1:0]       dbg_lfsr
`ifdef TI_SHARE_CHECK_EN
    ,
    output logic                    err
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RND_W-1:0]   rnd;
    logic [RND_W-1:0]   rnd_nxt;
    logic [DW-1:0]      data;
    logic [LFSR_W-1:0]  lfsr;
    logic               accept;
    logic               gen_last;

    assign accept   = in_valid && in_ready;
    // A seed load in GEN restarts collection, so it can never end GEN.
    assign gen_last = (state == GEN) && !seed_load && (cnt == CNT_LAST);
    // The pre-step LSB is the bit collected this cycle.
    assign rnd_nxt  = {rnd[RND_W-2:0], lfsr[0]};

    ti_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step    (state == GEN),
        .load    (seed_load),
        .seed_in (seed_in),
        .value   (lfsr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = GEN;
            GEN:     if (gen_last)  state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == EMIT);
    end

    // Datapath: captured nibble, mask collection and registered shares
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            rnd        <= '0;
            data       <= '0;
            out_shares <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data <= in_data;
                        cnt  <= '0;
                        rnd  <= '0;
                    end
                end
                GEN: begin
                    if (seed_load) begin
                        cnt <= '0;
                        rnd <= '0;
                    end else begin
                        rnd <= rnd_nxt;
                        cnt <= cnt + 3'd1;
                        // Shares are formed on the edge that collects the
                        // eighth bit, so they are ready on entry to EMIT.
                        if (cnt == CNT_LAST) begin
                            out_shares <= share_pack(data, rnd_nxt);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_lfsr  = lfsr;

`ifdef TI_SHARE_CHECK_EN
    logic [DW-1:0] recombined;

    assign recombined = out_shares[DW-1:0] ^ out_shares[2*DW-1:DW] ^ out_shares[3*DW-1:2*DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == EMIT) && (recombined != data)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ti_share_encoder.sv
module tb_ti_share_encoder;
  import ti_share_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        seed_load = 1'b0;
  logic [15:0] seed_in   = 16'h0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data   = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_shares;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_lfsr;
`ifdef TI_SHARE_CHECK_EN
  logic        err;
`endif

  ti_share_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares),
    .dbg_state  (dbg_state),
    .dbg_lfsr   (dbg_lfsr)
`ifdef TI_SHARE_CHECK_EN
    ,
    .err        (err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] m_lfsr;         // model of LFSR contents while IDLE
  logic [11:0] exp_q[$];       // scoreboard: expected shares in order
  logic [3:0]  nib_q[$];       // nibbles accepted, for the XOR invariant

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [15:0] m_adv8(input logic [15:0] x);
    logic [15:0] y = x;
    for (int i = 0; i < 8; i++) y = m_step(y);
    return y;
  endfunction

  // First LFSR bit drawn becomes the MSB of the 8-bit random value.
  function automatic logic [11:0] m_shares(input logic [3:0] d, input logic [15:0] start);
    logic [15:0] x = start;
    int r = 0;
    logic [3:0] s1, s2, s0;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + int'(x[0]);
      x = m_step(x);
    end
    s1 = 4'(r % 16);
    s2 = 4'(r / 16);
    s0 = d ^ s1 ^ s2;
    return {s2, s1, s0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seed_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_in = s; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Called on a negedge with the DUT idle. Returns the number of negedges
  // after the acceptance edge up to and including the first with out_valid.
  task automatic send_and_wait(input logic [3:0] nib, output int n);
    in_valid = 1'b1; in_data = nib;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 30);
  endtask

  task automatic finish_emit();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_shares !== 12'h000) begin errors++; $display("FAIL reset_shares: got %h want 000", out_shares); end
    checks++; if (dbg_lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h want ace1", dbg_lfsr); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_basic();
    int n;
    load_seed(16'h0001);
    checks++; if (dbg_lfsr !== 16'h0001) begin errors++; $display("FAIL basic_seed: got %h want 0001", dbg_lfsr); end
    send_and_wait(4'h5, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", n); end
    checks++; if (out_shares !== 12'h80D) begin errors++; $display("FAIL basic_shares: got %h want 80d", out_shares); end
    checks++; if (dbg_lfsr !== 16'h0168) begin errors++; $display("FAIL basic_lfsr: got %h want 0168", dbg_lfsr); end
    finish_emit();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    m_lfsr = 16'h0168;
  endtask

  task automatic test_backpressure();
    int n;
    logic [3:0] nib = 4'($urandom_range(0, 15));
    logic [11:0] exp = m_shares(nib, m_lfsr);
    send_and_wait(nib, n);
    m_lfsr = m_adv8(m_lfsr);
    checks++; if (out_shares !== exp) begin errors++; $display("FAIL bp_shares: got %h want %h", out_shares, exp); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = ~nib;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_shares !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b s=%h r=%b want 1/%h/0", i, out_valid, out_shares, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    finish_emit();
    checks++; if (out_valid !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL bp_idle: got v=%b st=%0d want 0/IDLE", out_valid, dbg_state); end
    checks++; if (dbg_lfsr !== m_lfsr) begin errors++; $display("FAIL bp_lfsr: got %h want %h", dbg_lfsr, m_lfsr); end
  endtask

  task automatic test_zero_seed();
    int n;
    logic [3:0] nib = 4'($urandom_range(0, 15));
    load_seed(16'h0000);
    checks++; if (dbg_lfsr !== 16'hACE1) begin errors++; $display("FAIL zseed_lfsr: got %h want ace1", dbg_lfsr); end
    send_and_wait(nib, n);
    checks++; if (out_shares !== m_shares(nib, 16'hACE1)) begin errors++; $display("FAIL zseed_shares: got %h want %h", out_shares, m_shares(nib, 16'hACE1)); end
    finish_emit();
    m_lfsr = m_adv8(16'hACE1);
  endtask

  task automatic test_seed_restart();
    int n;
    load_seed(16'h1234);
    in_valid = 1'b1; in_data = 4'h5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (dbg_state !== GEN) begin errors++; $display("FAIL restart_in_gen: got %0d want GEN", dbg_state); end
    seed_in = 16'h0001; seed_load = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      seed_load = 1'b0;
      n++;
    end while (!out_valid && n < 30);
    checks++; if (n !== 9) begin errors++; $display("FAIL restart_latency: got %0d want 9", n); end
    checks++; if (out_shares !== 12'h80D) begin errors++; $display("FAIL restart_shares: got %h want 80d", out_shares); end
    finish_emit();
    m_lfsr = 16'h0168;
  endtask

  task automatic test_reset_abort();
    int n;
    logic [3:0] nib;
    in_valid = 1'b1; in_data = 4'hA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_lfsr !== 16'hACE1) begin
      errors++; $display("FAIL abort_gen: got v=%b r=%b lfsr=%h want 0/1/ace1", out_valid, in_ready, dbg_lfsr);
    end
    nib = 4'($urandom_range(0, 15));
    send_and_wait(nib, n);
    checks++; if (out_shares !== m_shares(nib, 16'hACE1)) begin errors++; $display("FAIL abort_post_shares: got %h want %h", out_shares, m_shares(nib, 16'hACE1)); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_lfsr !== 16'hACE1) begin
      errors++; $display("FAIL abort_emit: got v=%b r=%b lfsr=%h want 0/1/ace1", out_valid, in_ready, dbg_lfsr);
    end
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_random();
    int n;
    int budget;
    logic [3:0] nib;
    logic [11:0] exp;
    logic [3:0] got_nib;
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      nib = 4'($urandom());
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready%0d: got %b want 1", t, in_ready); end
      exp_q.push_back(m_shares(nib, m_lfsr));
      nib_q.push_back(nib);
      m_lfsr = m_adv8(m_lfsr);
      send_and_wait(nib, n);
      exp = exp_q.pop_front();
      got_nib = nib_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_shares !== exp) begin
        errors++; $display("FAIL rnd_shares%0d: got v=%b s=%h want 1/%h", t, out_valid, out_shares, exp);
      end
      checks++; if ((out_shares[3:0] ^ out_shares[7:4] ^ out_shares[11:8]) !== got_nib) begin
        errors++; $display("FAIL rnd_xor%0d: got %h want %h", t, out_shares[3:0] ^ out_shares[7:4] ^ out_shares[11:8], got_nib);
      end
      budget = 0;
      do begin
        out_ready = (budget > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        budget++;
        if (out_valid && out_shares !== exp) begin
          errors++; $display("FAIL rnd_stable%0d: got %h want %h", t, out_shares, exp);
        end
      end while (out_valid && budget < 40);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_release%0d: got %b want 0", t, out_valid); end
    end
`ifdef TI_SHARE_CHECK_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b want 0", err); end
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_seed();
    test_seed_restart();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
